// File: rtl/calpart_pkg.sv
// Shared definitions for the calpart microcoded sequencer: instruction fields,
// class and ALU op codes, FSM states and the datapath control bundle.
package calpart_pkg;

  localparam int PROG_ADDR_W = 6;
  localparam int INSTR_W     = 12;

  localparam int CLS_LSB = 9;
  localparam int OP_LSB  = 6;
  localparam int RD_LSB  = 4;
  localparam int RA_LSB  = 2;
  localparam int RB_LSB  = 0;

  localparam logic [2:0] CLS_NOP  = 3'b000;
  localparam logic [2:0] CLS_IN   = 3'b001;
  localparam logic [2:0] CLS_OUT  = 3'b010;
  localparam logic [2:0] CLS_ALU  = 3'b011;
  localparam logic [2:0] CLS_CMP  = 3'b100;
  localparam logic [2:0] CLS_JMP  = 3'b101;
  localparam logic [2:0] CLS_JZ   = 3'b110;
  localparam logic [2:0] CLS_HALT = 3'b111;

  localparam logic [2:0] OP_PASS_A = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_SUB    = 3'b010;
  localparam logic [2:0] OP_AND    = 3'b011;
  localparam logic [2:0] OP_OR     = 3'b100;
  localparam logic [2:0] OP_XOR    = 3'b101;
  localparam logic [2:0] OP_NOT_A  = 3'b110;
  localparam logic [2:0] OP_PASS_B = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_WAIT_IN  = 3'd3,
    ST_WAIT_OUT = 3'd4
  } state_e;

  typedef struct packed {
    logic       ie;
    logic       ze;
    logic       oe;
    logic       we;
    logic [1:0] wa;
    logic       rae;
    logic [1:0] raa;
    logic       rbe;
    logic [1:0] rba;
    logic [2:0] op;
    logic [3:0] cal_value;
    logic       in_ready;
    logic       out_valid;
  } ctrl_t;

  function automatic logic [2:0] get_cls(input logic [INSTR_W-1:0] instr);
    return instr[CLS_LSB +: 3];
  endfunction

  function automatic logic [2:0] get_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_LSB +: 3];
  endfunction

  function automatic logic [1:0] get_reg(input logic [INSTR_W-1:0] instr, input int lsb);
    return instr[lsb +: 2];
  endfunction

endpackage

// File: rtl/calpart_if.sv
// Bus bundle between the sequencer, its program memory, the datapath and the
// top-level start/done control.
interface calpart_if;
  import calpart_pkg::*;

  logic                   start;
  logic                   busy;
  logic                   done;
  logic [PROG_ADDR_W-1:0] imem_addr;
  logic                   imem_en;
  logic [INSTR_W-1:0]     imem_data;
  logic                   Q;
  logic                   in_valid;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic                   IE;
  logic                   ZE;
  logic                   OE;
  logic                   WE;
  logic                   RAE;
  logic                   RBE;
  logic [1:0]             WA;
  logic [1:0]             RAA;
  logic [1:0]             RBA;
  logic [2:0]             OP;
  logic [3:0]             Cal_value;

  modport master (
    input  start, imem_data, Q, in_valid, out_ready,
    output busy, done, imem_addr, imem_en, in_ready, out_valid,
    output IE, ZE, OE, WE, RAE, RBE, WA, RAA, RBA, OP, Cal_value
  );

  modport slave (
    output start, imem_data, Q, in_valid, out_ready,
    input  busy, done, imem_addr, imem_en, in_ready, out_valid,
    input  IE, ZE, OE, WE, RAE, RBE, WA, RAA, RBA, OP, Cal_value
  );

endinterface

// File: rtl/calpart_decode.sv
// Combinational map from sequencer state and current instruction to the
// datapath control bundle; everything not driven by a state/class is zero.
module calpart_decode
  import calpart_pkg::*;
(
  input  state_e             state,
  input  logic [INSTR_W-1:0] instr,
  input  logic               in_valid,
  output ctrl_t              ctrl
);

  logic [2:0] cls;

  assign cls = get_cls(instr);

  // Control bundle per state and instruction class
  always_comb begin
    ctrl = '{default: 1'b0};
    case (state)
      ST_EXEC: begin
        case (cls)
          CLS_ALU, CLS_CMP: begin
            ctrl.rae       = 1'b1;
            ctrl.rbe       = 1'b1;
            ctrl.raa       = get_reg(instr, RA_LSB);
            ctrl.rba       = get_reg(instr, RB_LSB);
            ctrl.op        = get_op(instr);
            ctrl.cal_value = instr[3:0];
            ctrl.we        = (cls == CLS_ALU);
            ctrl.wa        = get_reg(instr, RD_LSB);
            ctrl.ze        = 1'b1;
          end
          default: begin
            ctrl = '{default: 1'b0};
          end
        endcase
      end
      ST_WAIT_IN: begin
        ctrl.ie       = 1'b1;
        ctrl.wa       = get_reg(instr, RD_LSB);
        ctrl.we       = in_valid;
        ctrl.in_ready = in_valid;
      end
      ST_WAIT_OUT: begin
        ctrl.rae       = 1'b1;
        ctrl.raa       = get_reg(instr, RA_LSB);
        ctrl.op        = OP_PASS_A;
        ctrl.oe        = 1'b1;
        ctrl.out_valid = 1'b1;
      end
      default: begin
        ctrl = '{default: 1'b0};
      end
    endcase
  end

endmodule

// File: rtl/calpart_sequencer.sv
// Microcoded sequencer: fetches 12-bit instructions from a synchronous-read
// program memory and drives the register-file/ALU datapath controls.
module calpart_sequencer
  import calpart_pkg::*;
(
  input logic        Clock,
  input logic        Reset_n,
  calpart_if.master  bus
);

  state_e                 state_q, state_d;
  logic [PROG_ADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0]     ir_q, ir_d;
  logic [PROG_ADDR_W-1:0] pc_inc;
  logic [PROG_ADDR_W-1:0] target;
  logic [INSTR_W-1:0]     instr;
  logic [2:0]             cls;
  logic                   is_fetch;
  ctrl_t                  ctrl;

  // Memory data is only meaningful in EXEC; the wait states replay the held copy.
  assign instr    = (state_q == ST_EXEC) ? bus.imem_data : ir_q;
  assign cls      = get_cls(bus.imem_data);
  assign target   = bus.imem_data[PROG_ADDR_W-1:0];
  assign pc_inc   = pc_q + {{(PROG_ADDR_W-1){1'b0}}, 1'b1};
  assign is_fetch = (state_q == ST_FETCH);

  // Next-state, program counter and instruction register
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_FETCH;
          pc_d    = {PROG_ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        ir_d = bus.imem_data;
        case (cls)
          CLS_IN:   state_d = ST_WAIT_IN;
          CLS_OUT:  state_d = ST_WAIT_OUT;
          CLS_JMP:  begin pc_d = target; state_d = ST_FETCH; end
          CLS_JZ:   begin pc_d = bus.Q ? target : pc_inc; state_d = ST_FETCH; end
          CLS_HALT: state_d = ST_IDLE;
          default:  begin pc_d = pc_inc; state_d = ST_FETCH; end
        endcase
      end
      ST_WAIT_IN: begin
        if (bus.in_valid) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WAIT_IN;
        end
      end
      ST_WAIT_OUT: begin
        if (bus.out_ready) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WAIT_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = {PROG_ADDR_W{1'b0}};
        ir_d    = {INSTR_W{1'b0}};
      end
    endcase
  end

  // State, pc and ir registers
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= {PROG_ADDR_W{1'b0}};
      ir_q    <= {INSTR_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  calpart_decode u_decode (
    .state    (state_q),
    .instr    (instr),
    .in_valid (bus.in_valid),
    .ctrl     (ctrl)
  );

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_EXEC) && (cls == CLS_HALT);
  assign bus.imem_en   = is_fetch;
  assign bus.imem_addr = is_fetch ? pc_q : {PROG_ADDR_W{1'b0}};
  assign bus.IE        = ctrl.ie;
  assign bus.ZE        = ctrl.ze;
  assign bus.OE        = ctrl.oe;
  assign bus.WE        = ctrl.we;
  assign bus.WA        = ctrl.wa;
  assign bus.RAE       = ctrl.rae;
  assign bus.RAA       = ctrl.raa;
  assign bus.RBE       = ctrl.rbe;
  assign bus.RBA       = ctrl.rba;
  assign bus.OP        = ctrl.op;
  assign bus.Cal_value = ctrl.cal_value;
  assign bus.in_ready  = ctrl.in_ready;
  assign bus.out_valid = ctrl.out_valid;

endmodule

// File: tb/tb_calpart_sequencer.sv
// Bench for calpart_sequencer: an instruction-level interpreter predicts every
// cycle's outputs while directed and random programs run from a memory model.
module tb_calpart_sequencer;
  import calpart_pkg::*;

  logic Clock   = 1'b0;
  logic Reset_n = 1'b0;

  calpart_if bus ();

  calpart_sequencer dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  logic [11:0] mem [64];

  // Synchronous-read program memory
  always @(posedge Clock) begin
    if (bus.imem_en) bus.imem_data <= mem[bus.imem_addr];
  end

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en;
    logic [5:0] addr;
    logic       in_ready;
    logic       out_valid;
    logic       ie;
    logic       ze;
    logic       oe;
    logic       we;
    logic [1:0] wa;
    logic       rae;
    logic [1:0] raa;
    logic       rbe;
    logic [1:0] rba;
    logic [2:0] op;
    logic [3:0] cal;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;
  bit q_queue[$];

  function automatic obs_t sample();
    obs_t o;
    o = '{busy: bus.busy, done: bus.done, en: bus.imem_en, addr: bus.imem_addr,
          in_ready: bus.in_ready, out_valid: bus.out_valid, ie: bus.IE, ze: bus.ZE,
          oe: bus.OE, we: bus.WE, wa: bus.WA, rae: bus.RAE, raa: bus.RAA,
          rbe: bus.RBE, rba: bus.RBA, op: bus.OP, cal: bus.Cal_value};
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [11:0] enc(input logic [2:0] c, input logic [2:0] op,
                                      input logic [1:0] rd, input logic [1:0] ra,
                                      input logic [1:0] rbf);
    return {c, op, rd, ra, rbf};
  endfunction

  function automatic logic [11:0] jmp(input logic [2:0] c, input logic [5:0] t);
    return {c, 3'b000, t};
  endfunction

  task automatic chk(input obs_t e, input string tag);
    obs_t o;
    o = sample();
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic cyc(input obs_t e, input logic st, input logic iv, input logic ordy,
                     input logic q, input string tag);
    bus.start     = st;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.Q         = q;
    #1;
    chk(e, tag);
    @(negedge Clock);
  endtask

  // Mid-handshake reset: outputs must clear without waiting for a clock edge
  task automatic abort_reset(input obs_t e, input string tag);
    obs_t z;
    z = '0;
    bus.start     = rb();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.Q         = rb();
    #1;
    chk(e, {tag, "_pre"});
    #2;
    Reset_n = 1'b0;
    #1;
    chk(z, {tag, "_async_clear"});
    @(negedge Clock);
    cyc(z, rb(), rb(), rb(), rb(), {tag, "_held"});
    Reset_n = 1'b1;
    cyc(z, 1'b0, rb(), rb(), rb(), {tag, "_idle1"});
    cyc(z, 1'b0, rb(), rb(), rb(), {tag, "_idle2"});
  endtask

  // Interpret the program in mem from address 0, predicting each cycle.
  // iv_force/or_low < 0 means random handshakes; or_low >= 0 holds out_ready
  // low for that many wait cycles.
  task automatic run_prog(input int abort_cls, input int iv_force, input int or_low,
                          input logic start_on_done);
    int          pc, budget, nwait;
    logic [11:0] ins;
    logic [2:0]  cls;
    logic [5:0]  next_pc;
    obs_t        e;
    logic        q, iv, ordy;
    bit          fin;
    pc = 0; budget = 2000; fin = 1'b0;
    e = '0;
    cyc(e, 1'b1, rb(), rb(), rb(), "idle_start");
    while (!fin) begin
      if (budget <= 0) begin
        n_checks++;
        $error("FAIL timeout: observed no HALT within budget expected HALT");
        break;
      end
      budget -= 2;
      ins = mem[pc]; cls = ins[11:9]; next_pc = 6'(pc + 1);
      e = '0; e.busy = 1'b1; e.en = 1'b1; e.addr = 6'(pc);
      cyc(e, rb(), rb(), rb(), rb(), $sformatf("fetch@%0d", pc));
      q = rb();
      if (cls == CLS_JZ && q_queue.size() > 0) q = q_queue.pop_front();
      e = '0; e.busy = 1'b1;
      case (cls)
        CLS_ALU, CLS_CMP: begin
          e.rae = 1'b1; e.rbe = 1'b1; e.raa = ins[3:2]; e.rba = ins[1:0];
          e.op = ins[8:6]; e.cal = ins[3:0]; e.we = (cls == CLS_ALU);
          e.wa = ins[5:4]; e.ze = 1'b1;
        end
        CLS_JMP:  next_pc = ins[5:0];
        CLS_JZ:   if (q) next_pc = ins[5:0];
        CLS_HALT: begin e.done = 1'b1; fin = 1'b1; end
        default:  ;
      endcase
      cyc(e, (cls == CLS_HALT) ? start_on_done : rb(), rb(), rb(), q,
          $sformatf("exec@%0d", pc));
      if (cls == CLS_IN) begin
        nwait = 0;
        do begin
          iv = (iv_force >= 0) ? iv_force[0] : rb();
          e = '0; e.busy = 1'b1; e.ie = 1'b1; e.wa = ins[5:4];
          if (abort_cls == int'(CLS_IN)) begin
            abort_reset(e, "reset_in");
            return;
          end
          e.we = iv; e.in_ready = iv;
          cyc(e, rb(), iv, rb(), rb(), $sformatf("wait_in@%0d.%0d", pc, nwait));
          nwait++; budget--;
        end while (!iv && budget > 0);
      end
      if (cls == CLS_OUT) begin
        nwait = 0;
        do begin
          ordy = (or_low >= 0) ? (nwait >= or_low) : rb();
          e = '0; e.busy = 1'b1; e.rae = 1'b1; e.raa = ins[3:2];
          e.op = OP_PASS_A; e.oe = 1'b1; e.out_valid = 1'b1;
          if (abort_cls == int'(CLS_OUT)) begin
            abort_reset(e, "reset_out");
            return;
          end
          cyc(e, rb(), rb(), ordy, rb(), $sformatf("wait_out@%0d.%0d", pc, nwait));
          nwait++; budget--;
        end while (!ordy && budget > 0);
      end
      pc = int'(next_pc);
    end
    e = '0;
    cyc(e, 1'b0, rb(), rb(), rb(), "idle_after1");
    cyc(e, 1'b0, rb(), rb(), rb(), "idle_after2");
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 64; a++) mem[a] = jmp(CLS_HALT, 6'd0);
  endtask

  task automatic load_p1();
    clear_mem();
    mem[0] = enc(CLS_IN,   3'd0, 2'd1, 2'd0, 2'd0);
    mem[1] = enc(CLS_IN,   3'd0, 2'd2, 2'd0, 2'd0);
    mem[2] = enc(CLS_ALU,  OP_SUB, 2'd3, 2'd1, 2'd2);
    mem[3] = enc(CLS_OUT,  3'd0, 2'd0, 2'd3, 2'd0);
    mem[4] = jmp(CLS_HALT, 6'd0);
  endtask

  initial begin
    obs_t z;
    int   n;
    logic [11:0] r;
    z = '0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.Q = 1'b0;
    clear_mem();
    #2;
    chk(z, "reset_state");
    @(negedge Clock);
    Reset_n = 1'b1;
    cyc(z, 1'b0, 1'b1, 1'b1, 1'b1, "idle_ignores_handshake");

    // IN, IN, ALU, OUT, HALT with in_valid high; start on the done cycle
    load_p1();
    run_prog(-1, 1, 0, 1'b1);

    // OUT stalled for five cycles
    run_prog(-1, -1, 5, 1'b0);

    // CMP then JZ taken / not taken
    clear_mem();
    mem[0] = enc(CLS_CMP, OP_SUB, 2'd0, 2'd0, 2'd0);
    mem[1] = jmp(CLS_JZ, 6'h20);
    q_queue.push_back(1'b1);
    run_prog(-1, -1, -1, 1'b0);
    q_queue.push_back(1'b0);
    run_prog(-1, -1, -1, 1'b0);

    // Wrap from 0x3F to 0x00, then JMP
    clear_mem();
    mem[0]     = jmp(CLS_JZ, 6'h3F);
    mem[1]     = jmp(CLS_JMP, 6'h10);
    mem[6'h3F] = enc(CLS_NOP, 3'd0, 2'd0, 2'd0, 2'd0);
    q_queue.push_back(1'b1);
    q_queue.push_back(1'b0);
    run_prog(-1, -1, -1, 1'b0);

    // Random forward-only programs
    for (int k = 0; k < 6; k++) begin
      clear_mem();
      n = $urandom_range(10, 40);
      for (int a = 0; a < n; a++) begin
        r = 12'($urandom);
        r[11:9] = 3'($urandom_range(0, 6));
        if (r[11:9] == CLS_JMP || r[11:9] == CLS_JZ) r[5:0] = 6'($urandom_range(a + 1, n));
        mem[a] = r;
      end
      run_prog(-1, -1, -1, rb());
    end

    // Reset during WAIT_IN and WAIT_OUT, then a clean restart from 0
    load_p1();
    run_prog(int'(CLS_IN), 1, 0, 1'b0);
    run_prog(int'(CLS_OUT), 1, 0, 1'b0);
    run_prog(-1, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
